// File: rtl/ahb_lite_master_arbiter.sv
// ahb_lite_master_arbiter: N-master AHB-Lite arbiter and bus mux with fixed-priority or round-robin grant, burst lock and tenure limit
module ahb_lite_master_arbiter #(
  parameter int NUM_M    = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int MAX_HOLD = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NUM_M*ADDR_W-1:0]  M_HADDR,
  input  logic [NUM_M*2-1:0]       M_HTRANS,
  input  logic [NUM_M-1:0]         M_HWRITE,
  input  logic [NUM_M*3-1:0]       M_HSIZE,
  input  logic [NUM_M*DATA_W-1:0]  M_HWDATA,
  input  logic [NUM_M-1:0]         M_HBUSREQ,
  output logic [NUM_M-1:0]         M_HGRANT,
  output logic [NUM_M-1:0]         M_HREADY,
  output logic [DATA_W-1:0]        M_HRDATA,
  output logic [ADDR_W-1:0]        S_HADDR,
  output logic [1:0]               S_HTRANS,
  output logic                     S_HWRITE,
  output logic [2:0]               S_HSIZE,
  output logic [DATA_W-1:0]        S_HWDATA,
  input  logic                     S_HREADY,
  input  logic [DATA_W-1:0]        S_HRDATA,
  output logic [2:0]               OWNER
);
  localparam int HW = $clog2(MAX_HOLD + 2);
  logic [ADDR_W-1:0] haddr [8];
  logic [1:0] htrans [8];
  logic [2:0] hsize [8];
  logic [DATA_W-1:0] hwdata [8];
  logic [7:0] hwrite, req, cand;
  logic [2:0] addr_own, data_own, rr_ptr, winner, idx;
  logic [HW-1:0] hold_cnt;
  logic own_idle, hold_hit, arb;
  // Slots beyond NUM_M read as idle non-requesters so they can never win
  for (genvar i = 0; i < 8; i++) begin : g_m
    if (i < NUM_M) begin : g_on
      assign haddr[i] = M_HADDR[i*ADDR_W +: ADDR_W];
      assign htrans[i] = M_HTRANS[i*2 +: 2];
      assign hsize[i] = M_HSIZE[i*3 +: 3];
      assign hwdata[i] = M_HWDATA[i*DATA_W +: DATA_W];
      assign hwrite[i] = M_HWRITE[i];
      assign req[i] = M_HBUSREQ[i];
      assign M_HGRANT[i] = addr_own == 3'(i);
      assign M_HREADY[i] = S_HREADY && (addr_own == 3'(i) || data_own == 3'(i));
    end else begin : g_off
      assign haddr[i] = '0;
      assign htrans[i] = 2'b00;
      assign hsize[i] = 3'b000;
      assign hwdata[i] = '0;
      assign hwrite[i] = 1'b0;
      assign req[i] = 1'b0;
    end
  end
  assign S_HADDR = haddr[addr_own];
  assign S_HTRANS = htrans[addr_own];
  assign S_HWRITE = hwrite[addr_own];
  assign S_HSIZE = hsize[addr_own];
  assign S_HWDATA = hwdata[data_own];
  assign M_HRDATA = S_HRDATA;
  assign OWNER = addr_own;
  always_comb begin
    own_idle = htrans[addr_own] == 2'b00;
    hold_hit = MAX_HOLD != 0 && S_HREADY && htrans[addr_own] == 2'b10 && hold_cnt == HW'(MAX_HOLD - 1);
    arb = S_HREADY && htrans[addr_own] != 2'b11 && (!req[addr_own] || own_idle || hold_hit);
    cand = (ARB_MODE == 1 && hold_hit && |(req & ~(8'd1 << addr_own))) ? req & ~(8'd1 << addr_own) : req;
    winner = addr_own;
    idx = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      idx = ARB_MODE == 1 ? 3'((int'(rr_ptr) + k) % NUM_M) : 3'(k);
      winner = cand[idx] ? idx : winner;
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_own <= '0;
      data_own <= '0;
      rr_ptr <= '0;
      hold_cnt <= '0;
    end else if (S_HREADY) begin
      data_own <= addr_own;
      if (arb && winner != addr_own) begin
        addr_own <= winner;
        hold_cnt <= '0;
        if (ARB_MODE == 1) rr_ptr <= 3'((int'(winner) + 1) % NUM_M);
      end else if (!own_idle && hold_cnt != HW'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// tb_ahb_lite_master_arbiter: scoreboard bench for a fixed-priority and a round-robin arbiter instance
module tb_ahb_lite_master_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] addr_v [3];
  logic [31:0] wdata_v [3];
  logic [1:0] trans_v [3];
  logic [2:0] req_v, wr_v;
  logic s_hready;
  logic [31:0] s_hrdata;
  logic [95:0] m_haddr, m_hwdata;
  logic [5:0] m_htrans;
  logic [8:0] m_hsize;
  logic [2:0] a_grant, a_ready, a_hsize, a_owner, b_grant, b_ready, b_hsize, b_owner;
  logic [31:0] a_rdata, a_haddr, a_hwdata, b_rdata, b_haddr, b_hwdata;
  logic [1:0] a_htrans, b_htrans;
  logic a_hwrite, b_hwrite;
  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  assign m_haddr = {addr_v[2], addr_v[1], addr_v[0]};
  assign m_hwdata = {wdata_v[2], wdata_v[1], wdata_v[0]};
  assign m_htrans = {trans_v[2], trans_v[1], trans_v[0]};
  assign m_hsize = 9'b010_010_010;

  always #5 clk = ~clk;

  ahb_lite_master_arbiter #(.NUM_M(3), .DATA_W(32), .ADDR_W(32), .ARB_MODE(0), .MAX_HOLD(0)) u_a (
    .HCLK(clk), .HRESET(rst), .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HWRITE(wr_v),
    .M_HSIZE(m_hsize), .M_HWDATA(m_hwdata), .M_HBUSREQ(req_v), .M_HGRANT(a_grant),
    .M_HREADY(a_ready), .M_HRDATA(a_rdata), .S_HADDR(a_haddr), .S_HTRANS(a_htrans),
    .S_HWRITE(a_hwrite), .S_HSIZE(a_hsize), .S_HWDATA(a_hwdata), .S_HREADY(s_hready),
    .S_HRDATA(s_hrdata), .OWNER(a_owner));

  ahb_lite_master_arbiter #(.NUM_M(3), .DATA_W(32), .ADDR_W(32), .ARB_MODE(1), .MAX_HOLD(2)) u_b (
    .HCLK(clk), .HRESET(rst), .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HWRITE(wr_v),
    .M_HSIZE(m_hsize), .M_HWDATA(m_hwdata), .M_HBUSREQ(req_v), .M_HGRANT(b_grant),
    .M_HREADY(b_ready), .M_HRDATA(b_rdata), .S_HADDR(b_haddr), .S_HTRANS(b_htrans),
    .S_HWRITE(b_hwrite), .S_HSIZE(b_hsize), .S_HWDATA(b_hwdata), .S_HREADY(s_hready),
    .S_HRDATA(s_hrdata), .OWNER(b_owner));

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) wdata_v[i] = {4'hD, 4'(i), 24'(cyc)};
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      trans_v[i] = 2'b00;
      addr_v[i] = '0;
    end
    req_v = '0;
    wr_v = '1;
    s_hready = 1'b1;
    s_hrdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    addr_v[0] = 32'h0000_1234;
    trans_v[0] = 2'b10;
    #1;
    vectors++; if (a_grant !== 3'b001) begin errors++; $display("FAIL reset_grant_a got %b want 001", a_grant); end
    vectors++; if (b_grant !== 3'b001) begin errors++; $display("FAIL reset_grant_b got %b want 001", b_grant); end
    vectors++; if (a_owner !== 3'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", a_owner); end
    vectors++; if (a_haddr !== 32'h0000_1234) begin errors++; $display("FAIL reset_haddr got %h want 00001234", a_haddr); end
    vectors++; if (a_ready !== 3'b001) begin errors++; $display("FAIL reset_ready got %b want 001", a_ready); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    logic [31:0] q [$];
    logic [31:0] e;
    do_reset();
    trans_v[0] = 2'b10; addr_v[0] = 32'h2000_0000; req_v = 3'b001; wr_v[0] = 1'b0;
    #1;
    vectors++; if (a_haddr !== 32'h2000_0000) begin errors++; $display("FAIL read_haddr got %h want 20000000", a_haddr); end
    vectors++; if (a_grant !== 3'b001) begin errors++; $display("FAIL read_grant got %b want 001", a_grant); end
    vectors++; if (a_htrans !== 2'b10 || a_hwrite !== 1'b0) begin errors++; $display("FAIL read_ctrl got %b/%b want 10/0", a_htrans, a_hwrite); end
    q.push_back(32'hCAFE_F00D);
    tick();
    trans_v[0] = 2'b00; req_v = '0; s_hrdata = 32'hCAFE_F00D;
    #1;
    e = q.pop_front();
    vectors++; if (a_rdata !== e) begin errors++; $display("FAIL read_rdata got %h want %h", a_rdata, e); end
    vectors++; if (a_ready !== 3'b001) begin errors++; $display("FAIL read_ready got %b want 001", a_ready); end
  endtask

  task automatic test_fixed_priority();
    int q [$];
    int j;
    logic [1:0] m0t [5] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [1:0] m1t [5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    logic [31:0] m0a [5] = '{32'h100, 32'h104, 32'h108, 32'h0, 32'h0};
    logic [31:0] m1a [5] = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h0};
    logic m0r [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic m1r [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int eg [5] = '{0, 0, 0, 1, 1};
    logic [31:0] ea [5] = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h0};
    logic [2:0] er [5] = '{3'b001, 3'b001, 3'b001, 3'b011, 3'b010};
    do_reset();
    for (int t = 0; t < 5; t++) begin
      trans_v[0] = m0t[t]; addr_v[0] = m0a[t]; req_v[0] = m0r[t];
      trans_v[1] = m1t[t]; addr_v[1] = m1a[t]; req_v[1] = m1r[t];
      #1;
      vectors++; if (a_grant !== 3'(1 << eg[t])) begin errors++; $display("FAIL fp_grant t=%0d got %b want %b", t, a_grant, 3'(1 << eg[t])); end
      vectors++; if (a_haddr !== ea[t]) begin errors++; $display("FAIL fp_haddr t=%0d got %h want %h", t, a_haddr, ea[t]); end
      vectors++; if (a_ready !== er[t]) begin errors++; $display("FAIL fp_ready t=%0d got %b want %b", t, a_ready, er[t]); end
      if (q.size() > 0) begin
        j = q.pop_front();
        vectors++; if (a_hwdata !== {4'hD, 4'(j), 24'(cyc)}) begin errors++; $display("FAIL fp_hwdata t=%0d got %h want %h", t, a_hwdata, {4'hD, 4'(j), 24'(cyc)}); end
      end
      if (ea[t] != 0) q.push_back(eg[t]);
      tick();
    end
  endtask

  task automatic test_round_robin();
    int q [$];
    int j;
    int eg [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    do_reset();
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 3; i++) begin
        trans_v[i] = 2'b10;
        addr_v[i] = 32'h1000 * (i + 1);
      end
      req_v = 3'b111;
      #1;
      vectors++; if (b_grant !== 3'(1 << eg[t])) begin errors++; $display("FAIL rr_grant t=%0d got %b want %b", t, b_grant, 3'(1 << eg[t])); end
      vectors++; if (b_haddr !== 32'h1000 * (eg[t] + 1)) begin errors++; $display("FAIL rr_haddr t=%0d got %h want %h", t, b_haddr, 32'h1000 * (eg[t] + 1)); end
      if (q.size() > 0) begin
        j = q.pop_front();
        vectors++; if (b_hwdata !== {4'hD, 4'(j), 24'(cyc)}) begin errors++; $display("FAIL rr_hwdata t=%0d got %h want %h", t, b_hwdata, {4'hD, 4'(j), 24'(cyc)}); end
      end
      q.push_back(eg[t]);
      tick();
    end
  endtask

  task automatic test_burst_lock();
    logic [1:0] m0t [7] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [1:0] m1t [7] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [31:0] m1a [7] = '{32'h300, 32'h300, 32'h304, 32'h308, 32'h30C, 32'h0, 32'h0};
    logic m0r [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic m1r [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int eg [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic [31:0] ea [7] = '{32'h0, 32'h300, 32'h304, 32'h308, 32'h30C, 32'h0, 32'h40};
    logic [1:0] et [7] = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd2};
    logic [2:0] er [7] = '{3'b001, 3'b011, 3'b010, 3'b010, 3'b010, 3'b010, 3'b011};
    do_reset();
    for (int t = 0; t < 7; t++) begin
      trans_v[0] = m0t[t]; addr_v[0] = m0r[t] ? 32'h40 : 32'h0; req_v[0] = m0r[t];
      trans_v[1] = m1t[t]; addr_v[1] = m1a[t]; req_v[1] = m1r[t];
      #1;
      vectors++; if (b_grant !== 3'(1 << eg[t])) begin errors++; $display("FAIL burst_grant t=%0d got %b want %b", t, b_grant, 3'(1 << eg[t])); end
      vectors++; if (b_haddr !== ea[t] || b_htrans !== et[t]) begin errors++; $display("FAIL burst_addr t=%0d got %h/%b want %h/%b", t, b_haddr, b_htrans, ea[t], et[t]); end
      vectors++; if (b_ready !== er[t]) begin errors++; $display("FAIL burst_ready t=%0d got %b want %b", t, b_ready, er[t]); end
      tick();
    end
  endtask

  task automatic test_wait_states();
    int q [$];
    int cur = 0;
    logic prev_rdy = 1'b0;
    logic rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int eg [8] = '{0, 1, 1, 1, 1, 1, 1, 2};
    logic [31:0] ea [8] = '{32'h500, 32'h600, 32'h600, 32'h600, 32'h600, 32'h600, 32'h600, 32'h700};
    logic [2:0] er [8] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b110};
    do_reset();
    for (int t = 0; t < 8; t++) begin
      s_hready = rdy[t];
      trans_v[0] = t == 0 ? 2'b10 : 2'b00; addr_v[0] = t == 0 ? 32'h500 : 32'h0; req_v[0] = 1'b0;
      trans_v[1] = t < 7 ? 2'b10 : 2'b00; addr_v[1] = t < 7 ? 32'h600 : 32'h0; req_v[1] = t < 2;
      trans_v[2] = t >= 2 ? 2'b10 : 2'b00; addr_v[2] = t >= 2 ? 32'h700 : 32'h0; req_v[2] = t >= 2;
      #1;
      if (prev_rdy) cur = q.pop_front();
      vectors++; if (a_grant !== 3'(1 << eg[t])) begin errors++; $display("FAIL wait_grant t=%0d got %b want %b", t, a_grant, 3'(1 << eg[t])); end
      vectors++; if (a_haddr !== ea[t]) begin errors++; $display("FAIL wait_haddr t=%0d got %h want %h", t, a_haddr, ea[t]); end
      vectors++; if (a_ready !== er[t]) begin errors++; $display("FAIL wait_ready t=%0d got %b want %b", t, a_ready, er[t]); end
      vectors++; if (a_hwdata !== {4'hD, 4'(cur), 24'(cyc)}) begin errors++; $display("FAIL wait_hwdata t=%0d got %h want %h", t, a_hwdata, {4'hD, 4'(cur), 24'(cyc)}); end
      if (rdy[t]) q.push_back(eg[t]);
      prev_rdy = rdy[t];
      tick();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int t = 0; t < 4; t++) begin
      rst = t == 2;
      trans_v[2] = t < 2 ? 2'b10 : 2'b11;
      addr_v[2] = t < 2 ? 32'h800 : 32'h800 + 32'(4 * (t - 1));
      req_v = t < 3 ? 3'b100 : 3'b000;
      if (t == 3) trans_v[2] = 2'b00;
      #1;
      if (t == 1 || t == 2) begin
        vectors++; if (a_grant !== 3'b100 || b_grant !== 3'b100) begin errors++; $display("FAIL mrst_pre t=%0d got %b/%b want 100/100", t, a_grant, b_grant); end
      end
      if (t == 2) begin
        vectors++; if (u_b.hold_cnt !== 2'd1) begin errors++; $display("FAIL mrst_hold_pre got %0d want 1", u_b.hold_cnt); end
      end
      if (t == 3) begin
        vectors++; if (a_grant !== 3'b001 || b_grant !== 3'b001) begin errors++; $display("FAIL mrst_grant got %b/%b want 001/001", a_grant, b_grant); end
        vectors++; if (a_owner !== 3'd0 || b_owner !== 3'd0) begin errors++; $display("FAIL mrst_owner got %0d/%0d want 0/0", a_owner, b_owner); end
        vectors++; if (u_b.hold_cnt !== 2'd0) begin errors++; $display("FAIL mrst_hold got %0d want 0", u_b.hold_cnt); end
        vectors++; if (a_ready !== 3'b001) begin errors++; $display("FAIL mrst_ready got %b want 001", a_ready); end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) wdata_v[i] = '0;
    idle_all();
    test_reset();
    test_read();
    test_fixed_priority();
    test_round_robin();
    test_burst_lock();
    test_wait_states();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
